// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the CPU load/store port: one request at a time,
// LATENCY wait cycles, then a single-cycle ack carrying read data or an error flag.
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                cur_we;
    logic [31:0]         cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                cur_err;
    logic [IDX_W-1:0]    mem_idx;
    logic                mem_we;

    always_comb begin
        // With LATENCY=0 the RESP entry edge is also the accept edge, so use live inputs there.
        cur_we    = (state_q == IDLE) ? we_i    : we_q;
        cur_addr  = (state_q == IDLE) ? addr_i  : addr_q;
        cur_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
        cur_err   = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
        mem_idx   = cur_addr[IDX_W+1:2];

        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // The memory access itself happens on the edge that enters RESP.
        if ((state_d == RESP) && (state_q != RESP)) begin
            err_d   = cur_err;
            rdata_d = (!cur_err && !cur_we) ? mem_q[mem_idx] : '0;
            mem_we  = !cur_err && cur_we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (mem_we) begin
                mem_q[mem_idx] <= cur_wdata;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign ack_o   = (state_q == RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
